iob_sram_sub: RTL and testbench
===============================

// Module: iob_sram_sub
// PURPOSE
//  IOb-native subordinate (responder) memory. It is the target-side counterpart of the CPU ibus/dbus IOb manager ports.
//  Word-organised register-array RAM with byte-lane writes, programmable wait states before ready,
//  and a fixed-latency, in-order, pipelined read-response path. Used as boot/scratch memory and as a bus-timing model.
// PARAMETERS
//  DATA_W       32  data width; multiple of 8
//  ADDR_W       32  byte-address width of iob_addr_i
//  MEM_ADDR_W   10  log2(depth in words)
//  READ_LAT     1   cycles from read ready to rvalid; legal 1..4
//  WAIT_STATES  0   cycles from first valid to ready; legal 0..7
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            synchronous active-high reset
//  cke_i        in   1            clock enable; 0 freezes all state
//  iob_valid_i  in   1            request valid
//  iob_addr_i   in   ADDR_W       byte address
//  iob_wdata_i  in   DATA_W       write data
//  iob_wstrb_i  in   DATA_W/8     byte strobes; 0 = read, nonzero = write
//  iob_ready_o  out  1            request accepted this cycle
//  iob_rvalid_o out  1            read data valid this cycle
//  iob_rdata_o  out  DATA_W       read data
//  err_o        out  1            sticky out-of-range access flag
// BEHAVIOUR
//  Reset: ready_o=0, rvalid_o=0, rdata_o=0, err_o=0, FSM=IDLE, wait counter=0, read pipeline emptied.
//   RAM contents are not reset.
//  Addressing:
//   - word index = addr[MEM_ADDR_W+B-1:B], where B=log2(DATA_W/8); low B bits are ignored.
//   - Any nonzero addr bit at or above MEM_ADDR_W+B means out-of-range.
//  Wait FSM (IDLE, WAIT):
//   - IDLE, valid=1, WAIT_STATES=0: ready_o=1 combinationally; stay IDLE.
//   - IDLE, valid=1, WAIT_STATES>0: go to WAIT with cnt=WAIT_STATES-1; ready_o=0.
//   - WAIT, cnt!=0: cnt decrements.
//   - WAIT, cnt=0: ready_o=1 for exactly one cycle; go to IDLE.
//   - Net effect: valid first seen in cycle t gives ready in cycle t+WAIT_STATES.
//   - valid low while in WAIT (protocol violation): return to IDLE; no access, no rvalid, no err.
//   - Manager holds addr/wdata/wstrb stable from valid until ready.
//     Back-to-back requests are legal, one per WAIT_STATES+1 cycles (one per cycle when WAIT_STATES=0).
//  Write (wstrb!=0):
//   - Committed at the clock edge ending the ready cycle; only strobed byte lanes are updated.
//   - No rvalid is produced.
//   - Out-of-range write: discarded, err_o set.
//  Read (wstrb=0):
//   - RAM is sampled at the edge ending the ready cycle.
//   - A write accepted in the preceding cycle is visible (no read-during-write hazard).
//   - Sampled data and a valid bit travel a READ_LAT-deep shift pipeline.
//   - rvalid_o=1 exactly READ_LAT cycles after the ready cycle, for one cycle.
//   - Responses are in order; up to READ_LAT reads may be in flight.
//   - Out-of-range read: accepted normally, returns 0 with rvalid, err_o set.
//  rdata_o: updated only on rvalid cycles; holds the last returned value otherwise.
//  err_o: set on any out-of-range access at its ready cycle; clears only on rst_i.
//  cke_i=0:
//   - FSM, counter, pipeline, RAM and err_o are frozen; ready_o and rvalid_o are forced 0.
//   - A response due during the frozen window is presented on the first cycle after cke_i returns to 1.
//  rst_i mid-operation: in-flight reads are dropped (no rvalid); a write in its ready cycle is not committed.
//  rst_i has priority over cke_i.
// TESTING
//  1. WAIT=0, LAT=1: write 0xDEADBEEF @0x10, wstrb=0xF -> ready same cycle.
//     Then read @0x10 -> ready same cycle, rvalid next cycle, rdata=0xDEADBEEF.
//  2. Preload 0x11223344 @0x20; write 0x000000AA, wstrb=0x1 -> read @0x20 returns 0x112233AA;
//     wstrb=0xC with 0x55660000 -> 0x556633AA.
//  3. LAT=3: reads @0x0, 0x4, 0x8 in cycles t, t+1, t+2 -> rvalid in t+3, t+4, t+5 with matching data, in order.
//  4. WAIT=2: valid held from t -> ready only in t+2.
//     Repeat with valid dropped at t+1 -> no ready, RAM unchanged, no rvalid.
//  5. MEM_ADDR_W=10: read @0x1000 -> ready, rvalid, rdata=0, err_o=1 until rst_i;
//     write @0x1000 leaves word 0 unchanged.
//  6. LAT=2: rst_i pulsed in cycle after read ready -> no rvalid, all outputs 0.
//     Also: cke_i=0 across the rvalid cycle -> rvalid appears on first cke_i=1 cycle, data correct.

Source files
------------

// File: rtl/iob_sram_sub_if.sv
// IOb request/response bundle between a manager and the SRAM subordinate.
// Request fields stay stable from valid until ready.
interface iob_sram_sub_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                iob_valid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic                iob_ready;
  logic                iob_rvalid;
  logic [DATA_W-1:0]   iob_rdata;

  modport master (
    output iob_valid,
    output iob_addr,
    output iob_wdata,
    output iob_wstrb,
    input  iob_ready,
    input  iob_rvalid,
    input  iob_rdata
  );

  modport slave (
    input  iob_valid,
    input  iob_addr,
    input  iob_wdata,
    input  iob_wstrb,
    output iob_ready,
    output iob_rvalid,
    output iob_rdata
  );
endinterface

// File: rtl/iob_sram_sub.sv
// IOb subordinate RAM: byte-lane writes, wait states before ready,
// fixed-latency in-order read pipeline, sticky out-of-range flag.
module iob_sram_sub #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int READ_LAT    = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cke_i,
  iob_sram_sub_if.slave bus,
  output logic          err_o
);

  localparam int NB    = DATA_W / 8;
  localparam int B     = $clog2(NB);
  localparam int HI    = MEM_ADDR_W + B;
  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam int LI    = READ_LAT - 1;

  localparam logic [2:0] CNT_INIT =
    3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic                  ready;
  logic                  acc;
  logic                  wr;
  logic                  rd;
  logic                  oor;
  logic                  rvalid;
  logic [MEM_ADDR_W-1:0] widx;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [DATA_W-1:0]   pd_q [READ_LAT];
  logic [DATA_W-1:0]   pd_d [READ_LAT];
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  assign widx = bus.iob_addr[HI-1:B];

  if (ADDR_W > HI) begin : g_oor
    assign oor = |bus.iob_addr[ADDR_W-1:HI];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  if (B > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^bus.iob_addr[B-1:0];
  end

  // ready is gated by cke and reset so a frozen or
  // resetting cycle never accepts anything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    if (cke_i && !rst_i) begin
      unique case (1'b1)
        state_q == S_IDLE: begin
          if (bus.iob_valid) begin
            if (WAIT_STATES == 0) begin
              ready = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        state_q == S_WAIT: begin
          if (!bus.iob_valid) begin
            state_d = S_IDLE;
          end else if (cnt_q == 3'd0) begin
            ready   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc = ready;
  assign wr  = acc & (|bus.iob_wstrb);
  assign rd  = acc & ~(|bus.iob_wstrb);

  always_ff @(posedge clk_i) begin
    if (wr && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.iob_wstrb[i]) begin
          mem_q[widx][8*i +: 8] <= bus.iob_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    pv_d     = pv_q;
    pd_d     = pd_q;
    pv_d[0]  = rd;
    pd_d[0]  = oor ? '0 : mem_q[widx];
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  assign rvalid = cke_i & ~rst_i & pv_q[LI];

  always_comb begin
    rdata_d = rvalid ? pd_q[LI] : rdata_q;
    err_d   = err_q | (acc & oor);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else if (cke_i) begin
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.iob_ready  = ready;
  assign bus.iob_rvalid = rvalid;
  assign bus.iob_rdata  = rdata_d;
  assign err_o          = err_q;

endmodule

// File: tb/tb_iob_sram_sub.sv
// Bench for iob_sram_sub: three configurations against a
// transaction-level memory/response model plus directed literals.
module tb_iob_sram_sub;

  localparam int NI = 3;

  function automatic int ws_of(input int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic int rl_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic cke;
  always #5 clk = ~clk;

  logic        valid_t [NI];
  logic [31:0] addr_t  [NI];
  logic [31:0] wdata_t [NI];
  logic [3:0]  wstrb_t [NI];
  logic        rdy     [NI];
  logic        rvld    [NI];
  logic [31:0] rdat    [NI];
  logic        errs    [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    iob_sram_sub_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    assign bus.iob_valid = valid_t[g];
    assign bus.iob_addr  = addr_t[g];
    assign bus.iob_wdata = wdata_t[g];
    assign bus.iob_wstrb = wstrb_t[g];
    assign rdy[g]  = bus.iob_ready;
    assign rvld[g] = bus.iob_rvalid;
    assign rdat[g] = bus.iob_rdata;
    iob_sram_sub #(
      .DATA_W(32),
      .ADDR_W(32),
      .MEM_ADDR_W(10),
      .READ_LAT(rl_of(g)),
      .WAIT_STATES(ws_of(g))
    ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .cke_i(cke),
      .bus(bus),
      .err_o(errs[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rnd_cke = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: memory image, pending responses with
  // remaining active cycles, run length of valid for wait states
  logic [31:0] mm [NI][1024];
  int          run_m [NI];
  logic [31:0] rd_m  [NI];
  logic        err_m [NI];

  typedef struct {
    int          k;
    int          rem;
    logic [31:0] d;
  } rsp_t;
  rsp_t pq[$];

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] d;
  } ev_t;
  ev_t rv_log[$];

  task automatic chk(input int k, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d: got %h want %h",
               nm, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < NI; k++) begin
        int          fi;
        logic        er;
        logic        ev;
        logic        oor;
        int          idx;
        fi = -1;
        for (int i = 0; i < pq.size(); i++) begin
          if (fi < 0 && pq[i].k == k) fi = i;
        end
        er = !rst && cke && valid_t[k] && run_m[k] == ws_of(k);
        ev = 1'b0;
        if (!rst && cke && fi >= 0) ev = (pq[fi].rem == 0);
        if (ev) rd_m[k] = pq[fi].d;
        if (rvld[k] === 1'b1) rv_log.push_back('{k, cyc, rdat[k]});
        chk(k, "ready", 32'(rdy[k]), 32'(er));
        chk(k, "rvalid", 32'(rvld[k]), 32'(ev));
        chk(k, "rdata", rdat[k], rd_m[k]);
        chk(k, "err", 32'(errs[k]), 32'(err_m[k]));
        if (rst) begin
          run_m[k] = 0;
          rd_m[k]  = '0;
          err_m[k] = 1'b0;
          for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].k == k) pq.delete(i);
          end
        end else if (cke) begin
          if (ev) pq.delete(fi);
          for (int i = 0; i < pq.size(); i++) begin
            if (pq[i].k == k) pq[i].rem = pq[i].rem - 1;
          end
          if (er) begin
            oor = |addr_t[k][31:12];
            idx = int'(addr_t[k][11:2]);
            if (oor) err_m[k] = 1'b1;
            if (wstrb_t[k] != 4'h0) begin
              for (int b = 0; b < 4; b++) begin
                if (!oor && wstrb_t[k][b])
                  mm[k][idx][8*b +: 8] = wdata_t[k][8*b +: 8];
              end
            end else begin
              pq.push_back('{k, rl_of(k) - 1,
                             oor ? 32'h0 : mm[k][idx]});
            end
          end
          run_m[k] = (er || !valid_t[k]) ? 0 : run_m[k] + 1;
        end
      end
    end
  end

  function automatic int find_rv(input int k, input int after,
                                 input int n);
    int c;
    c = 0;
    for (int i = 0; i < rv_log.size(); i++) begin
      if (rv_log[i].k == k && rv_log[i].cyc > after) begin
        if (c == n) return i;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic chk_rv(input int k, input int after, input int n,
                        input int ecyc, input logic [31:0] ed);
    int i;
    i = find_rv(k, after, n);
    chk(k, "rv_cycle", (i < 0) ? 32'hFFFF_FFFF : 32'(rv_log[i].cyc),
        32'(ecyc));
    chk(k, "rv_data", (i < 0) ? 32'hxxxx_xxxx : rv_log[i].d, ed);
  endtask

  task automatic step_cke();
    cke = rnd_cke ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step_cke();
    end
  endtask

  task automatic do_req(input int k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int rc, output int wc);
    valid_t[k] = 1'b1;
    addr_t[k]  = a;
    wdata_t[k] = d;
    wstrb_t[k] = s;
    wc = 0;
    rc = -1;
    step_cke();
    forever begin
      @(negedge clk);
      if (rdy[k]) begin
        rc = cyc;
        break;
      end
      wc++;
      if (wc > 100) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout[%0d] got none want ready", k);
        break;
      end
      @(posedge clk);
      #1;
      step_cke();
    end
    @(posedge clk);
    #1;
    valid_t[k] = 1'b0;
    addr_t[k]  = $urandom();
    wdata_t[k] = $urandom();
    wstrb_t[k] = 4'($urandom());
    step_cke();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, wc, r, cnt, w, op;
    logic [31:0] a;
    rst = 1'b1;
    cke = 1'b1;
    for (int k = 0; k < NI; k++) begin
      valid_t[k] = 1'b0;
      addr_t[k]  = '0;
      wdata_t[k] = '0;
      wstrb_t[k] = '0;
      run_m[k]   = 0;
      rd_m[k]    = '0;
      err_m[k]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 64; i++) begin
        do_req(k, 32'(i * 4), {8'(k), 8'(i), 16'hC0DE}, 4'hF, rc, wc);
      end
    end

    // zero wait states, one cycle latency
    do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, rc, wc);
    chk(0, "t1_wr_wait", 32'(wc), 32'd0);
    do_req(0, 32'h10, 32'h0, 4'h0, rc, wc);
    chk(0, "t1_rd_wait", 32'(wc), 32'd0);
    idle(3);
    chk_rv(0, rc, 0, rc + 1, 32'hDEADBEEF);

    // byte lane merges
    do_req(0, 32'h20, 32'h11223344, 4'hF, rc, wc);
    do_req(0, 32'h20, 32'h000000AA, 4'h1, rc, wc);
    do_req(0, 32'h20, 32'h0, 4'h0, rc, wc);
    idle(3);
    chk_rv(0, rc, 0, rc + 1, 32'h112233AA);
    do_req(0, 32'h20, 32'h55660000, 4'hC, rc, wc);
    do_req(0, 32'h22, 32'h0, 4'h0, rc, wc);
    idle(3);
    chk_rv(0, rc, 0, rc + 1, 32'h556633AA);

    // three-deep pipelined reads
    do_req(1, 32'h0, 32'h000000A0, 4'hF, rc, wc);
    do_req(1, 32'h4, 32'h000000A4, 4'hF, rc, wc);
    do_req(1, 32'h8, 32'h000000A8, 4'hF, rc, wc);
    do_req(1, 32'h0, 32'h0, 4'h0, r, wc);
    do_req(1, 32'h4, 32'h0, 4'h0, rc, wc);
    chk(1, "t3_b2b", 32'(rc), 32'(r + 1));
    do_req(1, 32'h8, 32'h0, 4'h0, rc, wc);
    idle(6);
    chk_rv(1, r, 0, r + 3, 32'h000000A0);
    chk_rv(1, r, 1, r + 4, 32'h000000A4);
    chk_rv(1, r, 2, r + 5, 32'h000000A8);

    // wait states and an aborted request
    do_req(2, 32'h40, 32'h4040ABCD, 4'hF, rc, wc);
    chk(2, "t4_wait", 32'(wc), 32'd2);
    valid_t[2] = 1'b1;
    addr_t[2]  = 32'h40;
    wdata_t[2] = 32'h0BAD0BAD;
    wstrb_t[2] = 4'hF;
    cnt = 0;
    @(negedge clk);
    cnt += int'(rdy[2]);
    @(posedge clk);
    #1;
    valid_t[2] = 1'b0;
    @(negedge clk);
    cnt += int'(rdy[2]);
    chk(2, "t4_abort_ready", 32'(cnt), 32'd0);
    idle(2);
    do_req(2, 32'h40, 32'h0, 4'h0, rc, wc);
    chk(2, "t4_rd_wait", 32'(wc), 32'd2);
    idle(4);
    chk_rv(2, rc, 0, rc + 2, 32'h4040ABCD);

    // out-of-range accesses
    do_req(0, 32'h1000, 32'h0, 4'h0, rc, wc);
    chk(0, "t5_wait", 32'(wc), 32'd0);
    @(negedge clk);
    chk(0, "t5_err", 32'(errs[0]), 32'd1);
    idle(2);
    chk_rv(0, rc, 0, rc + 1, 32'h0);
    do_req(0, 32'h1000, 32'hFFFFFFFF, 4'hF, rc, wc);
    do_req(0, 32'h0, 32'h0, 4'h0, rc, wc);
    idle(3);
    chk_rv(0, rc, 0, rc + 1, 32'h0000C0DE);

    // reset drops an in-flight read
    do_req(2, 32'h40, 32'h0, 4'h0, r, wc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    chk(2, "t6_rst_drop", 32'(find_rv(2, r, 0)), 32'hFFFF_FFFF);
    @(negedge clk);
    chk(0, "t6_err_clr", 32'(errs[0]), 32'd0);

    // clock enable held low across the response cycle
    do_req(2, 32'h40, 32'h0, 4'h0, r, wc);
    @(posedge clk);
    #1;
    cke = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cke = 1'b1;
    idle(4);
    chk_rv(2, r, 0, r + 5, 32'h4040ABCD);

    // randomized traffic with random clock-enable stalls
    rnd_cke = 1'b1;
    for (int k = 0; k < NI; k++) begin
      repeat (150) begin
        w = int'($urandom_range(0, 63));
        a = 32'(w * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0)
          a = a | (32'h1 << $urandom_range(12, 31));
        op = int'($urandom_range(0, 7));
        if (k == 2 && op == 0) begin
          valid_t[k] = 1'b1;
          addr_t[k]  = a;
          wdata_t[k] = $urandom();
          wstrb_t[k] = 4'($urandom());
          @(posedge clk);
          #1;
          valid_t[k] = 1'b0;
          step_cke();
        end else if (op < 4) begin
          do_req(k, a, $urandom(), 4'($urandom_range(1, 15)), rc, wc);
        end else begin
          do_req(k, a, $urandom(), 4'h0, rc, wc);
        end
        idle(int'($urandom_range(0, 2)));
      end
    end
    rnd_cke = 1'b0;
    idle(10);
    chk(0, "drain", 32'(pq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
